// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, the opcode values
// understood by control_unit, and instruction field positions.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      ISSUE = 2'd1,
      FAULT = 2'd2
   } fetchState_t;

   localparam logic [4:0] OPC_L  = 5'b00000;
   localparam logic [4:0] OPC_I  = 5'b00001;
   localparam logic [4:0] OPC_AR = 5'b00010;
   localparam logic [4:0] OPC_J  = 5'b00011;
   localparam logic [4:0] OPC_M  = 5'b00100;
   localparam logic [4:0] OPC_P  = 5'b00111;
   localparam logic [4:0] OPC_Q  = 5'b01000;
   localparam logic [4:0] OPC_T  = 5'b01011;
   localparam logic [4:0] OPC_L2 = 5'b01100;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int JIMM_W = 22;

   // Instruction fetches are word-aligned; any set low bit is a fault.
   function automatic logic misalignedAddr(input logic [1:0] lowBits);
      return lowBits != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative jump, or
// register-relative branch, plus the word-alignment check on the result.
module next_pc_calc
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [JIMM_W-1:0] jImm,
   input  logic              pcSrc,
   input  logic              cOffset,
   input  logic [ADDR_W-1:0] regOffset,
   output logic [ADDR_W-1:0] nextPc,
   output logic              misaligned
);

   logic [ADDR_W-1:0] jDisp;

   // Jump immediate is a signed word count, so scale by 4 after extending.
   assign jDisp = {{(ADDR_W-JIMM_W-2){jImm[JIMM_W-1]}}, jImm, 2'b00};

   always_comb begin
      nextPc = pc + ADDR_W'(4);
      if (pcSrc) begin
         if (cOffset) begin
            nextPc = pc + regOffset;
         end else begin
            nextPc = pc + jDisp;
         end
      end
   end

   assign misaligned = misalignedAddr(nextPc[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the instruction register and issues it to control_unit.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [4:0]      NOP_OPCODE = OPC_P
) (
   input  logic              CLK,
   input  logic              RST_N,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              pcSrc,
   input  logic              C_offset,
   input  logic [31:0]       reg_offset,
   output logic [4:0]        opcode,
   output logic [31:0]       instr,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic              fault
);

   localparam logic [31:0] NOP_IR = {NOP_OPCODE, {OPC_LO{1'b0}}};

   fetchState_t       state, nextState;
   logic [ADDR_W-1:0] pcReg, pcNext;
   logic [31:0]       irReg, irNext;
   logic              reqReg, reqNext;
   logic              validReg, validNext;
   logic              faultReg, faultNext;

   logic [ADDR_W-1:0] targetPc;
   logic              targetMisaligned;

   next_pc_calc #(
      .ADDR_W(ADDR_W)
   ) nextPcCalc (
      .pc        (pcReg),
      .jImm      (irReg[JIMM_W-1:0]),
      .pcSrc     (pcSrc),
      .cOffset   (C_offset),
      .regOffset (reg_offset[ADDR_W-1:0]),
      .nextPc    (targetPc),
      .misaligned(targetMisaligned)
   );

   // Next-state logic. The request is raised one cycle after entering FETCH
   // from reset, but leaving ISSUE raises it directly so back-to-back
   // instructions sustain one issue every two cycles.
   always_comb begin
      nextState = state;
      pcNext    = pcReg;
      irNext    = irReg;
      reqNext   = reqReg;
      validNext = validReg;
      faultNext = faultReg;
      case (state)
         FETCH: begin
            if (!reqReg) begin
               reqNext = 1'b1;
            end else if (imem_ack) begin
               irNext    = imem_rdata;
               reqNext   = 1'b0;
               validNext = 1'b1;
               nextState = ISSUE;
            end
         end
         ISSUE: begin
            if (!stall) begin
               validNext = 1'b0;
               if (targetMisaligned) begin
                  faultNext = 1'b1;
                  nextState = FAULT;
               end else begin
                  pcNext    = targetPc;
                  reqNext   = 1'b1;
                  nextState = FETCH;
               end
            end
         end
         FAULT: begin
            reqNext   = 1'b0;
            validNext = 1'b0;
         end
         default: begin
            reqNext   = 1'b0;
            validNext = 1'b0;
            nextState = FETCH;
         end
      endcase
   end

   // Reset dominates every state, dropping any outstanding request.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= FETCH;
         pcReg    <= RESET_PC;
         irReg    <= NOP_IR;
         reqReg   <= 1'b0;
         validReg <= 1'b0;
         faultReg <= 1'b0;
      end else begin
         state    <= nextState;
         pcReg    <= pcNext;
         irReg    <= irNext;
         reqReg   <= reqNext;
         validReg <= validNext;
         faultReg <= faultNext;
      end
   end

   assign imem_req    = reqReg;
   assign imem_addr   = pcReg;
   assign opcode      = irReg[OPC_HI:OPC_LO];
   assign instr       = irReg;
   assign instr_valid = validReg;
   assign pc          = pcReg;
   assign fault       = faultReg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] NOP_WORD = 32'h3800_0000;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rstN, imemAck, stall, pcSrc, cOffset;
   logic [31:0] imemRdata, regOffset;
   logic        imemReq, instrValid, fault;
   logic [31:0] imemAddr, instr, pcOut;
   logic [4:0]  opcode;

   logic        rstNW;
   logic        reqW, validW, faultW;
   logic [31:0] addrW, instrW, pcW;
   logic [4:0]  opcodeW;

   int testsRun = 0;
   int testsFailed = 0;
   logic checking = 1'b1;

   logic [4:0] opcList [9] = '{OPC_AR, OPC_I, OPC_J, OPC_M, OPC_L, OPC_L2, OPC_Q, OPC_T, OPC_P};

   fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .CLK(CLK), .RST_N(rstN),
      .imem_req(imemReq), .imem_addr(imemAddr),
      .imem_ack(imemAck), .imem_rdata(imemRdata),
      .stall(stall), .pcSrc(pcSrc), .C_offset(cOffset), .reg_offset(regOffset),
      .opcode(opcode), .instr(instr), .instr_valid(instrValid),
      .pc(pcOut), .fault(fault)
   );

   fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
      .CLK(CLK), .RST_N(rstNW),
      .imem_req(reqW), .imem_addr(addrW),
      .imem_ack(1'b1), .imem_rdata(NOP_WORD),
      .stall(1'b0), .pcSrc(1'b0), .C_offset(1'b0), .reg_offset(32'h0),
      .opcode(opcodeW), .instr(instrW), .instr_valid(validW),
      .pc(pcW), .fault(faultW)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic ack, input logic [31:0] rd,
                                input logic st, input logic ps, input logic co, input logic [31:0] ro);
      rstN      = r;
      imemAck   = ack;
      imemRdata = rd;
      stall     = st;
      pcSrc     = ps;
      cOffset   = co;
      regOffset = ro;
   endtask

   // Behavioural model: PC, IR and three flags describing what the stage is doing.
   logic        mLive = 1'b0;
   logic [31:0] mPc, mIr;
   logic        mReq, mValid, mFault;

   task automatic modelStep();
      longint      off;
      logic [31:0] target;
      if (!rstN) begin
         mLive  = 1'b1;
         mPc    = 32'h0;
         mIr    = NOP_WORD;
         mReq   = 1'b0;
         mValid = 1'b0;
         mFault = 1'b0;
      end else if (mFault) begin
         mReq = 1'b0;
      end else if (mValid) begin
         if (!stall) begin
            if (!pcSrc) begin
               target = mPc + 32'd4;
            end else if (!cOffset) begin
               off    = $signed(mIr[21:0]);
               target = mPc + 32'(off * 4);
            end else begin
               target = mPc + regOffset;
            end
            mValid = 1'b0;
            if (target % 4 != 0) begin
               mFault = 1'b1;
            end else begin
               mPc  = target;
               mReq = 1'b1;
            end
         end
      end else if (!mReq) begin
         mReq = 1'b1;
      end else if (imemAck) begin
         mIr    = imemRdata;
         mReq   = 1'b0;
         mValid = 1'b1;
      end
   endtask

   initial begin : compareProc
      forever begin
         @(posedge CLK);
         modelStep();
         #1;
         if (mLive && checking) begin
            checkOutput("mdlReq", imemReq, mReq);
            checkOutput("mdlValid", instrValid, mValid);
            checkOutput("mdlFault", fault, mFault);
            checkOutput("mdlPc", pcOut, mPc);
            checkOutput("mdlInstr", instr, mIr);
            checkOutput("mdlOpcode", opcode, mIr[31:27]);
            if (mReq) checkOutput("mdlAddr", imemAddr, mPc);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: time limit reached before summary");
      $fatal(1, "[TB] watchdog");
   end

   task automatic waitReq(input string name, input logic [31:0] expAddr);
      int n = 0;
      while (imemReq !== 1'b1 && n < 20) begin
         imemAck = 1'b0;
         @(negedge CLK);
         n++;
      end
      checkOutput({name, "_req"}, imemReq, 1'b1);
      checkOutput({name, "_addr"}, imemAddr, expAddr);
   endtask

   // One instruction: fetch at expAddr (optionally slow), issue (optionally
   // stalled, optionally with stray acks), then leave ISSUE with the given branch inputs.
   task automatic doInstr(input string name, input logic [31:0] expAddr, input logic [31:0] rd,
                          input int ackDelay, input int stallCycles, input logic spurious,
                          input logic ps, input logic co, input logic [31:0] ro);
      waitReq(name, expAddr);
      for (int i = 0; i < ackDelay; i++) begin
         imemAck   = 1'b0;
         imemRdata = $urandom;
         @(negedge CLK);
         checkOutput({name, "_slowReq"}, imemReq, 1'b1);
         checkOutput({name, "_slowAddr"}, imemAddr, expAddr);
         checkOutput({name, "_slowValid"}, instrValid, 1'b0);
      end
      imemAck   = 1'b1;
      imemRdata = rd;
      @(negedge CLK);
      imemAck   = 1'b0;
      imemRdata = $urandom;
      checkOutput({name, "_valid"}, instrValid, 1'b1);
      checkOutput({name, "_instr"}, instr, rd);
      checkOutput({name, "_pc"}, pcOut, expAddr);
      for (int i = 0; i < stallCycles; i++) begin
         stall   = 1'b1;
         pcSrc   = 1'($urandom_range(0, 1));
         cOffset = 1'($urandom_range(0, 1));
         if (spurious) begin
            imemAck   = 1'b1;
            imemRdata = ~rd;
         end
         @(negedge CLK);
         checkOutput({name, "_stallValid"}, instrValid, 1'b1);
         checkOutput({name, "_stallPc"}, pcOut, expAddr);
         checkOutput({name, "_stallInstr"}, instr, rd);
      end
      imemAck   = 1'b0;
      stall     = 1'b0;
      pcSrc     = ps;
      cOffset   = co;
      regOffset = ro;
      @(negedge CLK);
      checkOutput({name, "_afterValid"}, instrValid, 1'b0);
      pcSrc     = 1'($urandom_range(0, 1));
      cOffset   = 1'($urandom_range(0, 1));
      regOffset = $urandom;
   endtask

   initial begin : stimulus
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      rstNW = 1'b0;

      // Reset held for three cycles; the wrap instance stays in reset for now.
      repeat (3) begin
         @(negedge CLK);
         checkOutput("rstOpcode", opcode, 5'b00111);
         checkOutput("rstReq", imemReq, 1'b0);
         checkOutput("rstValid", instrValid, 1'b0);
         checkOutput("rstFault", fault, 1'b0);
         checkOutput("rstPc", pcOut, 32'h0);
         checkOutput("rstWrapOpcode", opcodeW, 5'b00111);
         checkOutput("rstWrapValid", validW, 1'b0);
      end
      rstN = 1'b1;

      // Free-running sequential fetches with same-cycle ack.
      for (int a = 0; a < 16; a += 4) begin
         doInstr("seq", 32'(a), {opcList[a/4], 27'(a + 1)}, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
      end

      // J branch from 0x10 with immediate -2 words.
      doInstr("jmp", 32'h10, {OPC_J, 5'b0, 22'h3FFFFE}, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0);

      // Slow memory at the jump target, plus a stray ack while issuing.
      doInstr("slow", 32'h08, {OPC_I, 27'h55}, 3, 1, 1'b1, 1'b0, 1'b0, 32'h0);

      for (int a = 12; a < 32; a += 4) begin
         doInstr("seqB", 32'(a), {opcList[(a/4) % 9], 27'($urandom)}, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
      end

      // M branch with a two-cycle stall, back again, then a misaligned target.
      doInstr("mBr", 32'h20, {OPC_M, 27'h0}, 0, 2, 1'b0, 1'b1, 1'b1, 32'h100);
      doInstr("mBack", 32'h120, {OPC_M, 27'h1}, 1, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FF00);
      doInstr("mMis", 32'h20, {OPC_M, 27'h2}, 0, 0, 1'b0, 1'b1, 1'b1, 32'h102);
      repeat (4) begin
         checkOutput("faultFlag", fault, 1'b1);
         checkOutput("faultReq", imemReq, 1'b0);
         checkOutput("faultPc", pcOut, 32'h20);
         checkOutput("faultValid", instrValid, 1'b0);
         imemAck   = 1'($urandom_range(0, 1));
         imemRdata = $urandom;
         stall     = 1'($urandom_range(0, 1));
         @(negedge CLK);
      end

      // Reset clears the fault; then reset lands on an unacked request.
      rstN    = 1'b0;
      imemAck = 1'b0;
      @(negedge CLK);
      checkOutput("faultCleared", fault, 1'b0);
      rstN  = 1'b1;
      stall = 1'b0;
      doInstr("post", 32'h0, {OPC_Q, 27'h7}, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
      waitReq("mid", 32'h4);
      rstN      = 1'b0;
      imemAck   = 1'b1;
      imemRdata = 32'hDEAD_BEEF;
      @(negedge CLK);
      checkOutput("midRstReq", imemReq, 1'b0);
      checkOutput("midRstOpcode", opcode, 5'b00111);
      @(negedge CLK);
      checkOutput("midRstInstr", instr, NOP_WORD);
      rstN = 1'b1;
      @(negedge CLK);
      imemAck = 1'b0;
      checkOutput("midRelReq", imemReq, 1'b1);
      checkOutput("midRelAddr", imemAddr, 32'h0);
      checkOutput("midRelInstr", instr, NOP_WORD);

      // Wrap-around instance: fetch at FFFF_FFFC, then at 0.
      rstNW = 1'b1;
      @(negedge CLK);
      checkOutput("wrapReq0", reqW, 1'b1);
      checkOutput("wrapAddr0", addrW, 32'hFFFF_FFFC);
      @(negedge CLK);
      checkOutput("wrapValid", validW, 1'b1);
      checkOutput("wrapPc", pcW, 32'hFFFF_FFFC);
      checkOutput("wrapInstr", instrW, NOP_WORD);
      @(negedge CLK);
      checkOutput("wrapReq1", reqW, 1'b1);
      checkOutput("wrapAddr1", addrW, 32'h0);
      checkOutput("wrapFault", faultW, 1'b0);

      // Randomized traffic; the compare process checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         applyStimulus(($urandom_range(0, 99) != 0) && !(fault && $urandom_range(0, 3) == 0),
                       $urandom_range(0, 2) != 0,
                       $urandom,
                       $urandom_range(0, 2) == 0,
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
         @(negedge CLK);
      end

      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
